// File: rtl/pointer_bank_pkg.sv
// Shared types and default sizing for the pointer bank.
package pointer_bank_pkg;

  localparam int AW_DEF   = 16;
  localparam int DW_DEF   = 8;
  localparam int NPTR_DEF = 4;

  // What a byte write strobe does this cycle.
  typedef enum logic [1:0] {
    WR_NONE,
    WR_STAGE,
    WR_COMMIT,
    WR_DIRECT
  } wr_kind_e;

endpackage

// File: rtl/pointer_bank_if.sv
// Bus bundle between the internal data bus / address bus side and the pointer bank.
interface pointer_bank_if
  import pointer_bank_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NPTR = NPTR_DEF
);

  localparam int PW = $clog2(NPTR);
  localparam int BW = $clog2(AW / DW);

  logic [DW-1:0] di;
  logic          we;
  logic [PW-1:0] w_ptr;
  logic [BW-1:0] w_byte;
  logic          inc;
  logic [PW-1:0] inc_ptr;
  logic          swap;
  logic [PW-1:0] swap_ptr;
  logic [PW-1:0] addr_ptr;
  logic [AW-1:0] addr;
  logic [PW-1:0] rd_ptr;
  logic [BW-1:0] rd_byte;
  logic [DW-1:0] dout;
  logic          pending;
  logic          wrap;

  modport master (
    output di, we, w_ptr, w_byte, inc, inc_ptr, swap, swap_ptr,
           addr_ptr, rd_ptr, rd_byte,
    input  addr, dout, pending, wrap
  );

  modport slave (
    input  di, we, w_ptr, w_byte, inc, inc_ptr, swap, swap_ptr,
           addr_ptr, rd_ptr, rd_byte,
    output addr, dout, pending, wrap
  );

endinterface

// File: rtl/pointer_bank_reg.sv
// One physical address pointer: load has priority over increment,
// carry flags the all-ones value so the bank can raise wrap.
module pointer_reg #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] q,
  output logic          carry
);

  // Pointer register: async clear, load beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

  assign carry = &q;

endmodule

// File: rtl/pointer_bank.sv
// Bank of NPTR address pointers with byte-wise (optionally atomic) loading,
// logical->physical remapping via swap, increment with wrap flag and
// combinational address / data read muxes.
module pointer_bank
  import pointer_bank_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int NPTR   = NPTR_DEF,
  parameter bit ATOMIC = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  pointer_bank_if.slave  bus
);

  localparam int NBYTE    = AW / DW;
  localparam int PW       = $clog2(NPTR);
  localparam int BW       = $clog2(NBYTE);
  localparam int TOP_BYTE = NBYTE - 1;
  localparam int SW       = (NBYTE - 1) * DW;
  localparam logic [BW-1:0] TOP_IDX = BW'(TOP_BYTE);

  logic [PW-1:0]   map [NPTR];
  logic [SW-1:0]   staging;
  logic            pending_q;
  logic            wrap_q;

  logic [AW-1:0]   ptr_q [NPTR];
  logic [NPTR-1:0] ptr_carry;
  logic [NPTR-1:0] load_vec;
  logic [NPTR-1:0] inc_vec;

  wr_kind_e        wr_kind;
  logic [PW-1:0]   wr_phys;
  logic [PW-1:0]   inc_phys;
  logic            writes_ptr;
  logic            inc_hit;
  logic [AW-1:0]   load_val;

  function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] val,
                                             input logic [BW-1:0] idx,
                                             input logic [DW-1:0] b);
    logic [AW-1:0] r;
    r = val;
    for (int i = 0; i < NBYTE; i++) begin
      if (idx == BW'(i)) r[i*DW +: DW] = b;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] get_byte(input logic [AW-1:0] val,
                                             input logic [BW-1:0] idx);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTE; i++) begin
      if (idx == BW'(i)) r = val[i*DW +: DW];
    end
    return r;
  endfunction

  // Classify the byte strobe: stage a low byte, commit the top byte, or write straight through.
  always_comb begin
    wr_kind = WR_NONE;
    if (bus.we) begin
      if (!ATOMIC)                 wr_kind = WR_DIRECT;
      else if (bus.w_byte == TOP_IDX) wr_kind = WR_COMMIT;
      else                         wr_kind = WR_STAGE;
    end
  end

  // All logical indices resolve through the map as it stood at the start of the cycle.
  assign wr_phys    = map[bus.w_ptr];
  assign inc_phys   = map[bus.inc_ptr];
  assign writes_ptr = (wr_kind == WR_COMMIT) || (wr_kind == WR_DIRECT);
  // A write landing on the same physical pointer swallows the increment.
  assign inc_hit    = bus.inc && !(writes_ptr && (wr_phys == inc_phys));

  // Value presented to the written pointer: full commit or single-byte merge.
  always_comb begin
    load_val = '0;
    if (wr_kind == WR_COMMIT) begin
      load_val = {bus.di, staging};
    end else begin
      load_val = put_byte(ptr_q[wr_phys], bus.w_byte, bus.di);
    end
  end

  // One-hot load / increment enables per physical pointer.
  always_comb begin
    load_vec = '0;
    inc_vec  = '0;
    for (int p = 0; p < NPTR; p++) begin
      load_vec[p] = writes_ptr && (wr_phys == PW'(p));
      inc_vec[p]  = inc_hit && (inc_phys == PW'(p));
    end
  end

  for (genvar p = 0; p < NPTR; p++) begin : g_ptr
    pointer_reg #(.AW(AW)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load_vec[p]),
      .load_val (load_val),
      .inc      (inc_vec[p]),
      .q        (ptr_q[p]),
      .carry    (ptr_carry[p])
    );
  end

  // Logical->physical map: identity after reset, swap exchanges entry 0 with the partner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPTR; i++) map[i] <= PW'(i);
    end else if (bus.swap && (bus.swap_ptr != '0)) begin
      map[0]            <= map[bus.swap_ptr];
      map[bus.swap_ptr] <= map[0];
    end
  end

  // Shared staging of low bytes; emptied by a commit or by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      staging   <= '0;
      pending_q <= 1'b0;
    end else if (wr_kind == WR_STAGE) begin
      for (int b = 0; b < NBYTE - 1; b++) begin
        if (bus.w_byte == BW'(b)) staging[b*DW +: DW] <= bus.di;
      end
      pending_q <= 1'b1;
    end else if (wr_kind == WR_COMMIT) begin
      staging   <= '0;
      pending_q <= 1'b0;
    end
  end

  // Wrap flag: high for one cycle after an increment that rolled over from all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= inc_hit && ptr_carry[inc_phys];
    end
  end

  assign bus.addr    = ptr_q[map[bus.addr_ptr]];
  assign bus.dout    = get_byte(ptr_q[map[bus.rd_ptr]], bus.rd_byte);
  assign bus.pending = pending_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_pointer_bank.sv
// Bench for pointer_bank (AW=16, DW=8, NPTR=4, ATOMIC=1): directed vectors,
// a behavioural model checked every cycle, plus literal expectations.
module tb_pointer_bank;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  pointer_bank_if #(.AW(16), .DW(8), .NPTR(4)) bus ();

  pointer_bank #(.AW(16), .DW(8), .NPTR(4), .ATOMIC(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_ptr [4];
  logic [1:0]  m_map [4];
  logic [7:0]  m_stage;
  logic        m_pend;
  logic        m_wrap;

  always @(posedge clk or negedge rst) begin
    logic [1:0]  wp, ip, t;
    logic        wrote;
    logic [15:0] nv [4];
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_ptr[i] = 16'h0000;
        m_map[i] = 2'(i);
      end
      m_stage = 8'h00;
      m_pend  = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      wp    = m_map[bus.w_ptr];
      ip    = m_map[bus.inc_ptr];
      wrote = 1'b0;
      for (int i = 0; i < 4; i++) nv[i] = m_ptr[i];
      if (bus.we) begin
        if (bus.w_byte == 1'b0) begin
          m_stage = bus.di;
          m_pend  = 1'b1;
        end else begin
          nv[wp]  = {bus.di, m_stage};
          wrote   = 1'b1;
          m_stage = 8'h00;
          m_pend  = 1'b0;
        end
      end
      m_wrap = 1'b0;
      if (bus.inc && !(wrote && wp == ip)) begin
        m_wrap = (m_ptr[ip] == 16'hFFFF);
        nv[ip] = m_ptr[ip] + 16'd1;
      end
      for (int i = 0; i < 4; i++) m_ptr[i] = nv[i];
      if (bus.swap && bus.swap_ptr != 2'd0) begin
        t                 = m_map[0];
        m_map[0]          = m_map[bus.swap_ptr];
        m_map[bus.swap_ptr] = t;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] rv;
    rv = m_ptr[m_map[bus.rd_ptr]];
    check("model_addr", {16'h0, bus.addr}, {16'h0, m_ptr[m_map[bus.addr_ptr]]});
    check("model_dout", {24'h0, bus.dout}, {24'h0, bus.rd_byte ? rv[15:8] : rv[7:0]});
    check("model_pending", {31'h0, bus.pending}, {31'h0, m_pend});
    check("model_wrap", {31'h0, bus.wrap}, {31'h0, m_wrap});
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_strobes();
    bus.we   = 1'b0;
    bus.inc  = 1'b0;
    bus.swap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_strobes();
  endtask

  task automatic wr(input logic [1:0] p, input logic b, input logic [7:0] d);
    bus.we = 1'b1; bus.w_ptr = p; bus.w_byte = b; bus.di = d;
    tick();
  endtask

  task automatic load(input logic [1:0] p, input logic [15:0] v);
    wr(p, 1'b0, v[7:0]);
    wr(p, 1'b1, v[15:8]);
  endtask

  task automatic look(input logic [1:0] p, input logic b);
    bus.addr_ptr = p; bus.rd_ptr = p; bus.rd_byte = b;
    @(negedge clk);
  endtask

  task automatic expect_addr(input string name, input logic [1:0] p, input logic [15:0] v);
    look(p, 1'b0);
    check(name, {16'h0, bus.addr}, {16'h0, v});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    bus.di = '0; bus.w_ptr = '0; bus.w_byte = '0; bus.inc_ptr = '0;
    bus.swap_ptr = '0; bus.addr_ptr = '0; bus.rd_ptr = '0; bus.rd_byte = '0;
    idle_strobes();

    // Reset state on every pointer
    for (int p = 0; p < 4; p++) begin
      look(2'(p), 1'b1);
      check("rst_addr", {16'h0, bus.addr}, 32'h0000);
      check("rst_dout", {24'h0, bus.dout}, 32'h00);
    end
    check("rst_pending", {31'h0, bus.pending}, 32'h0);
    check("rst_wrap", {31'h0, bus.wrap}, 32'h0);
    #2 rst = 1'b1;

    // Atomic load of pointer 2
    wr(2'd2, 1'b0, 8'h34);
    expect_addr("atomic_stage_addr", 2'd2, 16'h0000);
    check("atomic_stage_pending", {31'h0, bus.pending}, 32'h1);
    wr(2'd2, 1'b1, 8'h12);
    expect_addr("atomic_commit_addr", 2'd2, 16'h1234);
    check("atomic_commit_pending", {31'h0, bus.pending}, 32'h0);
    look(2'd2, 1'b1);
    check("atomic_dout_hi", {24'h0, bus.dout}, 32'h12);

    // Plain increment, no wrap
    bus.inc = 1'b1; bus.inc_ptr = 2'd2; tick();
    expect_addr("inc_addr", 2'd2, 16'h1235);
    check("inc_nowrap", {31'h0, bus.wrap}, 32'h0);

    // Wrap from all-ones
    load(2'd1, 16'hFFFF);
    bus.inc = 1'b1; bus.inc_ptr = 2'd1; tick();
    expect_addr("wrap_addr", 2'd1, 16'h0000);
    check("wrap_high", {31'h0, bus.wrap}, 32'h1);
    tick();
    check("wrap_low", {31'h0, bus.wrap}, 32'h0);

    // Swap
    load(2'd0, 16'h1000);
    load(2'd3, 16'h2000);
    bus.swap = 1'b1; bus.swap_ptr = 2'd3; tick();
    expect_addr("swap_l0", 2'd0, 16'h2000);
    expect_addr("swap_l3", 2'd3, 16'h1000);
    bus.swap = 1'b1; bus.swap_ptr = 2'd3; tick();
    expect_addr("unswap_l0", 2'd0, 16'h1000);
    expect_addr("unswap_l3", 2'd3, 16'h2000);
    bus.swap = 1'b1; bus.swap_ptr = 2'd0; tick();
    expect_addr("swap0_l0", 2'd0, 16'h1000);
    // Write through swapped map lands on physical 3
    bus.swap = 1'b1; bus.swap_ptr = 2'd3; tick();
    load(2'd0, 16'h3000);
    expect_addr("remap_wr_l0", 2'd0, 16'h3000);
    expect_addr("remap_wr_l3", 2'd3, 16'h1000);
    bus.swap = 1'b1; bus.swap_ptr = 2'd3; tick();
    expect_addr("remap_back_l3", 2'd3, 16'h3000);
    // Swap and commit in the same edge: commit uses the old (identity) map
    wr(2'd1, 1'b0, 8'h00);
    bus.swap = 1'b1; bus.swap_ptr = 2'd3;
    bus.we = 1'b1; bus.w_ptr = 2'd0; bus.w_byte = 1'b1; bus.di = 8'h40;
    tick();
    expect_addr("swapwr_l3", 2'd3, 16'h4000);
    expect_addr("swapwr_l0", 2'd0, 16'h3000);
    bus.swap = 1'b1; bus.swap_ptr = 2'd3; tick();

    // Collision: commit beats increment
    load(2'd0, 16'h00FF);
    wr(2'd0, 1'b0, 8'h00);
    bus.inc = 1'b1; bus.inc_ptr = 2'd0;
    bus.we = 1'b1; bus.w_ptr = 2'd0; bus.w_byte = 1'b1; bus.di = 8'hAB;
    tick();
    expect_addr("collide_addr", 2'd0, 16'hAB00);
    check("collide_wrap", {31'h0, bus.wrap}, 32'h0);

    // Reset mid-sequence drops staged byte
    wr(2'd1, 1'b0, 8'h55);
    check("midrst_pending_pre", {31'h0, bus.pending}, 32'h1);
    #2 rst = 1'b0;
    #10 rst = 1'b1;
    @(negedge clk);
    check("midrst_pending_rst", {31'h0, bus.pending}, 32'h0);
    wr(2'd1, 1'b1, 8'h66);
    expect_addr("midrst_commit", 2'd1, 16'h6600);
    check("midrst_pending_post", {31'h0, bus.pending}, 32'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
